// File: rtl/fifo_ctrl_80x8.sv
// FIFO controller around an external 80x8 single-clock dual-port RAM.
// Pointers wrap explicitly at DEPTH-1; status flags decode the registered occupancy.
module fifo_ctrl_80x8 #(
  parameter int DEPTH    = 80,
  parameter int WIDTH    = 8,
  parameter int AW       = 7,
  parameter int AF_LEVEL = 76,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             ram_wrt_sig,
  output logic [AW-1:0]    ram_addr_w,
  output logic [AW-1:0]    ram_addr_r,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_CNT = AW'(DEPTH);
  localparam logic [AW-1:0] AF_CNT    = AW'(AF_LEVEL);
  localparam logic [AW-1:0] AE_CNT    = AW'(AE_LEVEL);
  localparam logic [AW-1:0] ONE       = AW'(1);

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    count_r;
  logic [AW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    if (ptr == LAST_IDX) begin
      return {AW{1'b0}};
    end else begin
      return ptr + ONE;
    end
  endfunction

  // Acceptance: a write into a full FIFO is allowed only alongside an accepted read.
  always_comb begin
    full_s   = (count_r == DEPTH_CNT);
    empty_s  = (count_r == {AW{1'b0}});
    rd_acc_s = rd_en & ~empty_s;
    wr_acc_s = wr_en & (~full_s | rd_acc_s);
  end

  // Occupancy next-state.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE;
      2'b01:   count_nxt_s = count_r - ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {AW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Read data capture: the RAM presents the head combinationally, so it is sampled on the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        dout_r <= ram_dout;
      end
      dout_valid_r <= rd_acc_s;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | (wr_en & ~wr_acc_s);
      underflow_r <= underflow_r | (rd_en & ~rd_acc_s);
    end
  end

  assign dout         = dout_r;
  assign dout_valid   = dout_valid_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_CNT);
  assign almost_empty = (count_r <= AE_CNT);
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign ram_wrt_sig  = wr_acc_s;
  assign ram_addr_w   = wr_ptr_r;
  assign ram_addr_r   = rd_ptr_r;
  assign ram_din      = din;

endmodule

// File: tb/tb_fifo_ctrl_80x8.sv
// Self-checking bench for fifo_ctrl_80x8: RAM model, queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_fifo_ctrl_80x8;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  logic       ram_wrt_sig;
  logic [6:0] ram_addr_w;
  logic [6:0] ram_addr_r;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  fifo_ctrl_80x8 dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .ram_wrt_sig(ram_wrt_sig),
    .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 80x8 RAM: synchronous write, combinational read
  logic [7:0] mem [0:79];
  initial for (int i = 0; i < 80; i++) mem[i] = 8'h00;
  always @(posedge clk) if (ram_wrt_sig && ram_addr_w < 7'd80) mem[ram_addr_w] <= ram_din;
  assign ram_dout = (ram_addr_r < 7'd80) ? mem[ram_addr_r] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO contents as a queue, pointers as total accepted ops modulo 80
  int       mq[$];
  bit       m_ovf, m_unf, m_dv;
  int       m_dout;
  int       m_wtot, m_rtot;

  function automatic bit pred_rd();
    return rd_en && (mq.size() > 0);
  endfunction
  function automatic bit pred_wr();
    return wr_en && (mq.size() < 80 || pred_rd());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = 0; m_wtot = 0; m_rtot = 0;
    end else begin
      bit r_ok, w_ok;
      r_ok = pred_rd();
      w_ok = pred_wr();
      m_ovf = m_ovf | (wr_en && !w_ok);
      m_unf = m_unf | (rd_en && !r_ok);
      m_dv  = r_ok;
      if (r_ok) begin
        m_dout = mq.pop_front();
        m_rtot++;
      end
      if (w_ok) begin
        mq.push_back(int'(din));
        m_wtot++;
      end
    end
  end

  // Single compare process: every output against the model, mid-cycle
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 80));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 76));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("ram_addr_w", 32'(ram_addr_w), 32'(m_wtot % 80));
    chk("ram_addr_r", 32'(ram_addr_r), 32'(m_rtot % 80));
    chk("ram_din", 32'(ram_din), 32'(din));
    chk("ram_wrt_sig", 32'(ram_wrt_sig), 32'(pred_wr()));
  end

  // Popped-data capture for literal sequence checks
  int cap[$];
  always @(negedge clk) if (dout_valid) cap.push_back(int'(dout));

  // Inputs are applied 2 time units after a rising edge and consumed by the next one
  task automatic step(input bit w, input bit r, input logic [7:0] d);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #2;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  int  exp_seq[$];
  bit  saw_wrap_w, saw_wrap_r;
  int  max_addr;
  logic [6:0] pw, pr;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    #23;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_ram_wrt_sig", 32'(ram_wrt_sig), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    step(0, 0, 8'h00);

    // three writes, three reads
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
    chk("three_count", 32'(count), 32'd3);
    cap.delete();
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    chk("seq_len", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      chk("seq0", 32'(cap[0]), 32'h11);
      chk("seq1", 32'(cap[1]), 32'h22);
      chk("seq2", 32'(cap[2]), 32'h33);
    end
    chk("drained_empty", 32'(empty), 32'd1);

    // fill to 80
    for (int i = 0; i < 80; i++) begin
      step(1, 0, 8'(i));
      chk("af_ramp", 32'(almost_full), 32'(i + 1 >= 76));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd80);
    step(1, 0, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd80);

    // simultaneous push/pop while full
    cap.delete();
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hA0 + i));
    chk("full_rw_count", 32'(count), 32'd80);
    for (int i = 0; i < 80; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    exp_seq.delete();
    for (int i = 0; i < 80; i++) exp_seq.push_back(i);
    for (int i = 0; i < 5; i++) exp_seq.push_back(8'hA0 + i);
    chk("full_rw_len", 32'(cap.size()), 32'd85);
    if (cap.size() == 85) begin
      chk("full_rw_4", 32'(cap[4]), 32'h04);
      chk("full_rw_5", 32'(cap[5]), 32'h05);
      chk("full_rw_79", 32'(cap[79]), 32'h4F);
      chk("full_rw_80", 32'(cap[80]), 32'hA0);
      chk("full_rw_84", 32'(cap[84]), 32'hA4);
      for (int i = 0; i < 85; i++) chk("full_rw_seq", 32'(cap[i]), 32'(exp_seq[i]));
    end

    // wrap: hold occupancy near 3 for 200 accepted writes
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom));
    saw_wrap_w = 0; saw_wrap_r = 0; max_addr = 0;
    begin
      int written;
      written = 0;
      while (written < 200) begin
        bit w, r;
        w = (mq.size() <= 2) ? 1'b1 : 1'($urandom);
        r = (mq.size() >= 4) ? 1'b1 : 1'($urandom);
        pw = ram_addr_w; pr = ram_addr_r;
        if (w) written++;
        step(w, r, 8'($urandom));
        if (pw == 7'd79 && ram_addr_w == 7'd0) saw_wrap_w = 1;
        if (pr == 7'd79 && ram_addr_r == 7'd0) saw_wrap_r = 1;
        if (int'(ram_addr_w) > max_addr) max_addr = int'(ram_addr_w);
        if (int'(ram_addr_r) > max_addr) max_addr = int'(ram_addr_r);
      end
    end
    chk("wrap_w_seen", 32'(saw_wrap_w), 32'd1);
    chk("wrap_r_seen", 32'(saw_wrap_r), 32'd1);
    chk("wrap_max_addr", 32'(max_addr), 32'd79);

    // underflow and empty simultaneous push/pop
    while (mq.size() > 0) step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_no_valid", 32'(dout_valid), 32'd0);
    step(1, 1, 8'h5A);
    chk("empty_rw_count", 32'(count), 32'd1);
    chk("empty_rw_no_valid", 32'(dout_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      step(w, r, 8'($urandom));
    end

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
    wr_en = 1'b1; din = 8'h77;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_almost_empty", 32'(almost_empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_unf", 32'(underflow), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_dout_valid", 32'(dout_valid), 32'd0);
    chk("arst_addr_w", 32'(ram_addr_w), 32'd0);
    chk("arst_addr_r", 32'(ram_addr_r), 32'd0);
    wr_en = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    step(1, 0, 8'h3C);
    step(0, 1, 8'h00);
    chk("post_rst_dout", 32'(dout), 32'h3C);
    step(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
